// File: rtl/rect80_inv_key_sched.sv
// RECTANGLE-80 inverse key schedule: runs the forward schedule to the final
// key state, then walks it backwards and streams round keys K25..K0.
module rect80_inv_key_sched #(
    parameter int         ROUNDS  = 25,
    parameter logic [4:0] RC_INIT = 5'h01
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [79:0] i_key,
    output logic        o_busy,
    output logic [63:0] o_rk,
    output logic        o_rk_valid,
    input  logic        i_rk_ready,
    output logic [4:0]  o_rk_idx,
    output logic        o_rk_last,
    output logic        o_done,
    output logic [1:0]  o_state
);

    // Stream handshake: a key transfers on any edge where o_rk_valid and
    // i_rk_ready are both high; while valid && !ready the key outputs hold.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(ROUNDS);

    state_t      state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  rc_q, rc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h6;  4'h1: y = 4'h5;  4'h2: y = 4'hC;  4'h3: y = 4'hA;
            4'h4: y = 4'h1;  4'h5: y = 4'hE;  4'h6: y = 4'h7;  4'h7: y = 4'h9;
            4'h8: y = 4'hB;  4'h9: y = 4'h0;  4'hA: y = 4'h3;  4'hB: y = 4'hD;
            4'hC: y = 4'h8;  4'hD: y = 4'hF;  4'hE: y = 4'h4;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hF;  4'h3: y = 4'hA;
            4'h4: y = 4'hE;  4'h5: y = 4'h1;  4'h6: y = 4'h0;  4'h7: y = 4'h6;
            4'h8: y = 4'hC;  4'h9: y = 4'h7;  4'hA: y = 4'h3;  4'hB: y = 4'h8;
            4'hC: y = 4'h2;  4'hD: y = 4'hB;  4'hE: y = 4'h5;  default: y = 4'hD;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] rotl8(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    function automatic logic [15:0] rotl12(input logic [15:0] x);
        return {x[3:0], x[15:4]};
    endfunction

    // Column j is {R3[j],R2[j],R1[j],R0[j]}; only columns 0..3 are substituted.
    function automatic logic [79:0] sub_cols(input logic [79:0] k, input logic inv);
        logic [79:0] r;
        logic [3:0]  nib;
        logic [3:0]  s;
        r = k;
        for (int j = 0; j < 4; j++) begin
            nib = {k[48+j], k[32+j], k[16+j], k[j]};
            s   = inv ? inv_sbox(nib) : sbox(nib);
            r[j]    = s[0];
            r[16+j] = s[1];
            r[32+j] = s[2];
            r[48+j] = s[3];
        end
        return r;
    endfunction

    function automatic logic [79:0] fwd_step(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        logic [15:0] n0;
        t  = sub_cols(k, 1'b0);
        n0 = rotl8(t[15:0]) ^ t[31:16];
        n0[4:0] = n0[4:0] ^ rc;
        return {t[15:0], rotl12(t[63:48]) ^ t[79:64], t[63:48], t[47:32], n0};
    endfunction

    function automatic logic [79:0] inv_step(input logic [79:0] k, input logic [4:0] rc);
        logic [15:0] n0;
        n0 = k[15:0];
        n0[4:0] = n0[4:0] ^ rc;
        return sub_cols({k[63:48] ^ rotl12(k[47:32]), k[47:32], k[31:16],
                         n0 ^ rotl8(k[79:64]), k[79:64]}, 1'b1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            rc_q    <= RC_INIT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    key_d   = i_key;
                    rc_d    = RC_INIT;
                    cnt_d   = '0;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (cnt_q == LAST_CNT) begin
                    // rc has run one past RC[ROUNDS-1]; pull it back for the first inverse step.
                    rc_d    = {rc_q[0] ^ rc_q[3], rc_q[4:1]};
                    state_d = EMIT;
                end else begin
                    key_d = fwd_step(key_q, rc_q);
                    rc_d  = {rc_q[3:0], rc_q[4] ^ rc_q[2]};
                    cnt_d = cnt_q + 5'd1;
                end
            end
            EMIT: begin
                if (i_rk_ready) begin
                    if (cnt_q != 5'd0) begin
                        key_d = inv_step(key_q, rc_q);
                        rc_d  = {rc_q[0] ^ rc_q[3], rc_q[4:1]};
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy     = (state_q != IDLE);
    assign o_rk_valid = (state_q == EMIT);
    assign o_rk       = o_rk_valid ? key_q[63:0] : 64'd0;
    assign o_rk_idx   = o_rk_valid ? cnt_q : 5'd0;
    assign o_rk_last  = o_rk_valid && (cnt_q == 5'd0);
    assign o_done     = done_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_rect80_inv_key_sched.sv
// Bench for rect80_inv_key_sched: forward-schedule reference model feeds an
// expected queue; a monitor pops and compares every accepted round key.
module tb_rect80_inv_key_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [79:0] i_key = '0;
    logic        i_rk_ready = 1'b1;
    logic        o_busy;
    logic [63:0] o_rk;
    logic        o_rk_valid;
    logic [4:0]  o_rk_idx;
    logic        o_rk_last;
    logic        o_done;
    logic [1:0]  o_state;

    int checks = 0;
    int errors = 0;
    logic ready_rand = 1'b0;

    // entry = {last, idx, rk}
    logic [69:0] exp_q[$];

    logic [3:0] sbox_tab [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                  4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
    logic [4:0] rc_tab [25] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16,
                                5'h0C, 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C,
                                5'h18, 5'h11, 5'h03, 5'h06, 5'h0D, 5'h1B, 5'h17, 5'h0E,
                                5'h1D};

    rect80_inv_key_sched dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (i_start),
        .i_key      (i_key),
        .o_busy     (o_busy),
        .o_rk       (o_rk),
        .o_rk_valid (o_rk_valid),
        .i_rk_ready (i_rk_ready),
        .o_rk_idx   (o_rk_idx),
        .o_rk_last  (o_rk_last),
        .o_done     (o_done),
        .o_state    (o_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_rk_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // reference model: forward schedule on a row array, RC taken from the table
    function automatic void model_push(input logic [79:0] key);
        logic [15:0] row [5];
        logic [15:0] t   [5];
        logic [63:0] rk  [26];
        logic [3:0]  nib;
        logic [3:0]  s;
        for (int r = 0; r < 5; r++) row[r] = key[16*r +: 16];
        rk[0] = {row[3], row[2], row[1], row[0]};
        for (int i = 0; i < 25; i++) begin
            for (int r = 0; r < 5; r++) t[r] = row[r];
            for (int j = 0; j < 4; j++) begin
                nib = {row[3][j], row[2][j], row[1][j], row[0][j]};
                s = sbox_tab[nib];
                for (int b = 0; b < 4; b++) t[b][j] = s[b];
            end
            row[0] = ((t[0] << 8) | (t[0] >> 8)) ^ t[1];
            row[1] = t[2];
            row[2] = t[3];
            row[3] = ((t[3] << 12) | (t[3] >> 4)) ^ t[4];
            row[4] = t[0];
            row[0][4:0] = row[0][4:0] ^ rc_tab[i];
            rk[i+1] = {row[3], row[2], row[1], row[0]};
        end
        for (int i = 25; i >= 0; i--) exp_q.push_back({(i == 0), 5'(i), rk[i]});
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    logic        stall_q  = 1'b0;
    logic [69:0] stall_val;
    logic        done_due = 1'b0;
    logic [69:0] exp_e;

    always @(negedge clk) begin
        if (rst) begin
            stall_q  = 1'b0;
            done_due = 1'b0;
        end else begin
            checks++;
            if (o_done !== done_due) begin
                errors++;
                $display("FAIL done_pulse: got %b expected %b", o_done, done_due);
            end
            if (o_rk_valid) begin
                if (stall_q) begin
                    checks++;
                    if ({o_rk_last, o_rk_idx, o_rk} !== stall_val) begin
                        errors++;
                        $display("FAIL stall_stable: got %h expected %h",
                                 {o_rk_last, o_rk_idx, o_rk}, stall_val);
                    end
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key: got idx %0d rk %h expected no output",
                             o_rk_idx, o_rk);
                end else if (i_rk_ready) begin
                    exp_e = exp_q.pop_front();
                    checks++;
                    if ({o_rk_last, o_rk_idx, o_rk} !== exp_e) begin
                        errors++;
                        $display("FAIL round_key: got last=%b idx=%0d rk=%h expected last=%b idx=%0d rk=%h",
                                 o_rk_last, o_rk_idx, o_rk, exp_e[69], exp_e[68:64], exp_e[63:0]);
                    end
                end
            end
            done_due  = o_rk_valid && i_rk_ready && o_rk_last;
            stall_q   = o_rk_valid && !i_rk_ready;
            stall_val = {o_rk_last, o_rk_idx, o_rk};
        end
    end

    // driver tasks
    task automatic launch(input logic [79:0] key, input logic do_lat);
        int  n;
        logic found;
        model_push(key);
        i_key   = key;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        chk("busy_after_start", 80'(o_busy), 80'd1);
        if (do_lat) begin
            n = 0;
            found = 1'b0;
            repeat (40) begin
                @(posedge clk);
                n++;
                @(negedge clk);
                if (o_rk_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("first_valid_cycle", 80'(n), 80'd26);
            chk("first_idx", 80'(o_rk_idx), 80'd25);
        end
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 80'(seen), 80'd1);
        chk("queue_drained", 80'(exp_q.size()), 80'd0);
    endtask

    function automatic logic [79:0] rand_key();
        return {16'($urandom()), 32'($urandom()), 32'($urandom())};
    endfunction

    initial begin
        logic seen;
        // reset held with start asserted
        rst = 1'b1;
        i_start = 1'b1;
        i_key = '0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_busy", 80'(o_busy), 80'd0);
            chk("rst_valid", 80'(o_rk_valid), 80'd0);
            chk("rst_rk", 80'(o_rk), 80'd0);
            chk("rst_idx_last_done", 80'({o_rk_idx, o_rk_last, o_done}), 80'd0);
            chk("rst_state", 80'(o_state), 80'd0);
        end
        rst = 1'b0;

        // zero key, ready held high
        launch(80'd0, 1'b1);
        wait_done();

        // fixed key with random backpressure
        ready_rand = 1'b1;
        launch(80'h0123_4567_89AB_CDEF_0F1E, 1'b1);
        wait_done();

        // all-ones key, stray starts during FWD and EMIT must be ignored
        launch({80{1'b1}}, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        i_key = rand_key();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        chk("busy_in_fwd", 80'(o_busy), 80'd1);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (o_rk_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("emit_reached", 80'(seen), 80'd1);
        @(posedge clk);
        #1;
        i_key = rand_key();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        chk("idle_after_run", 80'(o_state), 80'd0);

        // reset in the middle of EMIT at idx 12
        launch(rand_key(), 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (o_rk_valid && o_rk_idx == 5'd12) begin
                seen = 1'b1;
                break;
            end
        end
        chk("idx12_reached", 80'(seen), 80'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 80'(o_rk_valid), 80'd0);
        chk("midrst_state", 80'(o_state), 80'd0);
        chk("midrst_busy", 80'(o_busy), 80'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        launch(rand_key(), 1'b1);
        wait_done();

        // back-to-back: next start issued in the o_done cycle
        for (int r = 0; r < 3; r++) begin
            launch(rand_key(), 1'b0);
            wait_done();
        end
        launch(rand_key(), 1'b1);
        wait_done();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
